fp_i2f_conv: RTL and testbench

- Multi-cycle integer-to-single-precision converter for FCVT.S.W / FCVT.S.WU.
- This is the reverse direction of the FPU compare path: that path turns two floats into an integer 0/1 result; this block turns a 32-bit integer register value into an IEEE-754 binary32 result.
- Sits in the FPU next to the compare unit.
- Uses a start/busy/done handshake so the core stalls while normalization runs.

---
 rtl/fp_i2f_conv.sv | 102 ++++++++++
 tb/tb_fp_i2f_conv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp_i2f_conv.sv
// Multi-cycle int32/uint32 -> binary32 converter (FCVT.S.W / FCVT.S.WU) with a start/busy/done handshake.
// Optional macro FP_I2F_FAST_NORM_EN: normalize by 8 bits per cycle while the top byte is zero.
module fp_i2f_conv #(
    parameter logic [2:0] RM_DEFAULT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Num_In,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        NX
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

    state_t      state;
    logic [31:0] mag;
    logic [7:0]  exp_r;
    logic        sign_r;
    logic        zero_r;
    logic [2:0]  rm_r;

    logic [22:0] mant;
    logic        g_bit, s_bit, inc;
    logic [23:0] sum;
    logic [7:0]  exp_out;

    always_comb begin
        mant  = mag[30:8];
        g_bit = mag[7];
        s_bit = |mag[6:0];
        inc   = 1'b0;
        case (rm_r)
            3'b000:  inc = g_bit & (s_bit | mant[0]);
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_r & (g_bit | s_bit);
            3'b011:  inc = !sign_r & (g_bit | s_bit);
            3'b100:  inc = g_bit;
            default: inc = 1'b0;
        endcase
        // A carry out of the mantissa leaves sum[22:0] zero, so only exp needs fixing.
        sum     = {1'b0, mant} + {23'b0, inc};
        exp_out = exp_r + {7'b0, sum[23]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= 32'h0;
            NX     <= 1'b0;
            mag    <= 32'h0;
            exp_r  <= 8'h0;
            sign_r <= 1'b0;
            zero_r <= 1'b0;
            rm_r   <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rm_r   <= (rm > 3'b100) ? RM_DEFAULT : rm;
                        sign_r <= !is_unsigned & Num_In[31];
                        mag    <= (!is_unsigned & Num_In[31]) ? (~Num_In + 32'd1) : Num_In;
                        exp_r  <= 8'd158;
                        zero_r <= (Num_In == 32'h0);
                        busy   <= 1'b1;
                        state  <= NORM;
                    end
                end
                // Zero passes through NORM once so that minimum latency stays at two edges.
                NORM: begin
                    if (zero_r || mag[31]) begin
                        state <= ROUND;
                    end
`ifdef FP_I2F_FAST_NORM_EN
                    else if (mag[31:24] == 8'h0) begin
                        mag   <= mag << 8;
                        exp_r <= exp_r - 8'd8;
                    end
`endif
                    else begin
                        mag   <= mag << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                ROUND: begin
                    Result <= zero_r ? 32'h0 : {sign_r, exp_out, sum[22:0]};
                    NX     <= zero_r ? 1'b0 : (g_bit | s_bit);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_i2f_conv.sv
// Self-checking bench for fp_i2f_conv: directed corner cases plus randomized operands
// compared against an arithmetic rounding model.
module tb_fp_i2f_conv;
    logic        clk = 1'b0;
    logic        rst, start, is_unsigned, busy, done, NX;
    logic [31:0] Num_In, Result;
    logic [2:0]  rm;

    int n_tests = 0;
    int n_fail  = 0;

    fp_i2f_conv dut (
        .clk(clk), .rst(rst), .start(start), .Num_In(Num_In), .is_unsigned(is_unsigned),
        .rm(rm), .busy(busy), .done(done), .Result(Result), .NX(NX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Rounds |v| to 24 significant bits using integer quotient/remainder arithmetic.
    function automatic void ref_model(input logic [31:0] v, input logic uns, input logic [2:0] rmi,
                                      output logic [31:0] res, output logic nx, output int lat);
        longint unsigned m, q, rem, half;
        logic sg, inc;
        int p, e, lz, sh, r;
        r   = (rmi > 3'd4) ? 0 : int'(rmi);
        sg  = !uns && v[31];
        m   = sg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        res = 32'h0;
        nx  = 1'b0;
        lz  = 0;
        if (m != 0) begin
            p = 31;
            while (((m >> p) & 64'd1) == 0) p--;
            lz = 31 - p;
            e  = 127 + p;
            if (p <= 23) begin
                q = m << (23 - p); rem = 0; half = 1;
            end else begin
                sh = p - 23;
                q = m >> sh; rem = m & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
            end
            case (r)
                0:       inc = (rem > half) || (rem == half && q[0]);
                1:       inc = 1'b0;
                2:       inc = sg && rem != 0;
                3:       inc = !sg && rem != 0;
                default: inc = rem >= half;
            endcase
            q = q + {63'h0, inc};
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            res = {sg, e[7:0], q[22:0]};
            nx  = rem != 0;
        end
`ifdef FP_I2F_FAST_NORM_EN
        lat = 2 + lz / 8 + lz % 8;
`else
        lat = lz + 2;
`endif
    endfunction

    // Drives a request; if now_ is 0 it first aligns to a falling edge.
    task automatic issue(input logic [31:0] v, input logic uns, input logic [2:0] rmi, input bit now_);
        if (!now_) @(negedge clk);
        Num_In = v; is_unsigned = uns; rm = rmi; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
    endtask

    // Counts edges from accept to done; optionally pokes start/inputs mid-conversion.
    task automatic wait_done(input bit poke, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (poke && lat == 2) begin
                start = 1'b1; Num_In = $urandom; is_unsigned = $urandom_range(0, 1); rm = $urandom_range(0, 7);
            end else start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (lat > 60) begin
                chk("done_timeout", 32'h0, 32'h1);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [31:0] v, input logic uns, input logic [2:0] rmi,
                             input bit now_, input bit poke);
        logic [31:0] er; logic en; int el, lat;
        ref_model(v, uns, rmi, er, en, el);
        issue(v, uns, rmi, now_);
        wait_done(poke, lat);
        chk({tag, "_res"}, Result, er);
        chk({tag, "_nx"}, {31'h0, NX}, {31'h0, en});
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic directed(input string tag, input logic [31:0] v, input logic uns, input logic [2:0] rmi,
                            input logic [31:0] er, input logic en);
        int lat;
        issue(v, uns, rmi, 1'b0);
        wait_done(1'b0, lat);
        chk({tag, "_res"}, Result, er);
        chk({tag, "_nx"}, {31'h0, NX}, {31'h0, en});
    endtask

    initial begin
        int lat, seen;
        logic [31:0] v;
        rst = 1'b1; start = 1'b0; Num_In = 32'h0; is_unsigned = 1'b0; rm = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", Result, 32'h0);
        chk("rst_nx", {31'h0, NX}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Known answers
        directed("one_rne", 32'h1, 1'b0, 3'b000, 32'h3F800000, 1'b0);
        directed("m1_s_rne", 32'hFFFFFFFF, 1'b0, 3'b000, 32'hBF800000, 1'b0);
        directed("max_u_rne", 32'hFFFFFFFF, 1'b1, 3'b000, 32'h4F800000, 1'b1);
        directed("max_u_rtz", 32'hFFFFFFFF, 1'b1, 3'b001, 32'h4F7FFFFF, 1'b1);
        directed("minint", 32'h80000000, 1'b0, 3'b000, 32'hCF000000, 1'b0);
        directed("zero", 32'h0, 1'b0, 3'b011, 32'h00000000, 1'b0);
        directed("tie_rne", 32'h01000001, 1'b0, 3'b000, 32'h4B800000, 1'b1);
        directed("tie_rup", 32'h01000001, 1'b0, 3'b011, 32'h4B800001, 1'b1);
        directed("tie_rmm", 32'h01000001, 1'b0, 3'b100, 32'h4B800001, 1'b1);
        directed("neg_rdn", 32'hFEFFFFFF, 1'b0, 3'b010, 32'hCB800001, 1'b1);
        directed("neg_rup", 32'hFEFFFFFF, 1'b0, 3'b011, 32'hCB800000, 1'b1);
        directed("neg_rsv", 32'hFEFFFFFF, 1'b0, 3'b111, 32'hCB800000, 1'b1);

        // Latency corners through the model
        run_check("lat_one", 32'h1, 1'b0, 3'b000, 1'b0, 1'b0);
        run_check("lat_min", 32'h80000000, 1'b0, 3'b000, 1'b0, 1'b0);
        run_check("lat_zero", 32'h0, 1'b1, 3'b000, 1'b0, 1'b0);

        // Start and operand changes while busy are ignored
        run_check("poke", 32'h00012345, 1'b0, 3'b010, 1'b0, 1'b1);

        // Back-to-back: start driven in the done cycle
        run_check("b2b_a", 32'h00000F0F, 1'b1, 3'b000, 1'b0, 1'b0);
        run_check("b2b_b", 32'hDEADBEEF, 1'b0, 3'b100, 1'b1, 1'b0);

        // Reset during NORM aborts the conversion and clears outputs
        issue(32'h1, 1'b0, 3'b000, 1'b0);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_result", Result, 32'h0);
        chk("abort_nx", {31'h0, NX}, 32'h0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

        // Randomized operands with varied leading-zero counts
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom >> $urandom_range(0, 31);
                2:       v = ~($urandom >> $urandom_range(0, 31));
                default: v = (32'h1 << $urandom_range(0, 31)) | ($urandom & 32'h1FF);
            endcase
            run_check("rand", v, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
